// File: rtl/keypad_scan_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Function : Row-scanned matrix keypad with per-key debounce feeding a
//            first-word-fall-through key-event FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_TICKS = 250000,
    parameter int DEBOUNCE   = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CODE_W    = $clog2(ROWS * COLS)
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ROWS-1:0]   row_n,
    input  logic [COLS-1:0]   col_n,
    output logic              key_valid,
    input  logic              key_ready,
    output logic [CODE_W-1:0] key_code,
    output logic              key_release,
    output logic              key_held,
    output logic              overflow,
    input  logic              overflow_clr
);
    localparam int c_keys  = ROWS * COLS;
    localparam int c_row_w = $clog2(ROWS);
    localparam int c_col_w = $clog2(COLS);
    localparam int c_tmr_w = $clog2(SCAN_TICKS);
    localparam int c_deb_w = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_evt_w = CODE_W + 1;

    typedef enum logic [1:0] {
        ST_DWELL = 2'd0,
        ST_PROC  = 2'd1,
        ST_ADV   = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_tmr_w-1:0]  r_timer;
    logic                r_tick;
    logic [c_row_w-1:0]  r_row;
    logic [c_row_w-1:0]  w_row_next;
    logic [c_col_w-1:0]  r_col_idx;
    logic [COLS-1:0]     r_frame;
    logic [COLS-1:0]     r_col_meta;
    logic [COLS-1:0]     r_col_sync;

    logic [c_keys-1:0]   r_key_state;
    logic [c_deb_w-1:0]  r_deb_cnt [c_keys];
    logic [CODE_W-1:0]   w_key_idx;
    logic                w_sample;
    logic                w_state;
    logic [c_deb_w-1:0]  w_cnt;
    logic                w_flip;

    logic [c_evt_w-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  w_rd_next;
    logic [c_ptr_w:0]    r_count;
    logic [c_evt_w-1:0]  w_evt;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta <= '1;
            r_col_sync <= '1;
        end else begin
            r_col_meta <= col_n;
            r_col_sync <= r_col_meta;
        end
    end

    assign w_row_next = (r_row == c_row_w'(ROWS - 1)) ? '0 : r_row + c_row_w'(1);

    // The tick is a registered strobe one cycle after the timer tops out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_DWELL;
            r_timer   <= '0;
            r_tick    <= 1'b0;
            r_row     <= '0;
            row_n     <= ~ROWS'(1);
            r_col_idx <= '0;
            r_frame   <= '1;
        end else begin
            case (r_state)
                ST_DWELL: begin
                    if (r_tick) begin
                        r_tick    <= 1'b0;
                        r_frame   <= r_col_sync;
                        r_col_idx <= '0;
                        r_state   <= ST_PROC;
                    end else if (r_timer == c_tmr_w'(SCAN_TICKS - 1)) begin
                        r_tick <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_tmr_w'(1);
                    end
                end
                ST_PROC: begin
                    if (r_col_idx == c_col_w'(COLS - 1)) begin
                        r_state <= ST_ADV;
                    end else begin
                        r_col_idx <= r_col_idx + c_col_w'(1);
                    end
                end
                ST_ADV: begin
                    r_row   <= w_row_next;
                    row_n   <= ~(ROWS'(1) << w_row_next);
                    r_timer <= '0;
                    r_state <= ST_DWELL;
                end
                default: r_state <= ST_DWELL;
            endcase
        end
    end

    assign w_key_idx = CODE_W'(int'(r_row) * COLS + int'(r_col_idx));
    assign w_sample  = ~r_frame[r_col_idx];
    assign w_state   = r_key_state[w_key_idx];
    assign w_cnt     = r_deb_cnt[w_key_idx];
    assign w_flip    = (r_state == ST_PROC) && (w_sample != w_state) &&
                       (w_cnt == c_deb_w'(DEBOUNCE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_state <= '0;
            for (int k = 0; k < c_keys; k++) begin
                r_deb_cnt[k] <= '0;
            end
        end else if (r_state == ST_PROC) begin
            if (w_sample == w_state) begin
                r_deb_cnt[w_key_idx] <= '0;
            end else if (w_flip) begin
                r_key_state[w_key_idx] <= w_sample;
                r_deb_cnt[w_key_idx]   <= '0;
            end else begin
                r_deb_cnt[w_key_idx] <= w_cnt + c_deb_w'(1);
            end
        end
    end

    assign key_held = |r_key_state;

    assign w_evt     = {~w_sample, w_key_idx};
    assign key_valid = (r_count != '0);
    assign w_full    = (r_count == (c_ptr_w + 1)'(FIFO_DEPTH));
    assign w_pop     = key_valid && key_ready;
    assign w_wr_en   = w_flip && (!w_full || w_pop);
    assign w_drop    = w_flip && w_full && !w_pop;
    assign w_rd_next = r_rd_ptr + c_ptr_w'(1);

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_evt;
        end
    end

    // The head is a register so it keeps the last event once the FIFO drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            key_code    <= '0;
            key_release <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            r_count <= r_count + (c_ptr_w + 1)'(w_wr_en) - (c_ptr_w + 1)'(w_pop);
            if (w_wr_en && ((r_count == '0) || (w_pop && r_count == (c_ptr_w + 1)'(1)))) begin
                {key_release, key_code} <= w_evt;
            end else if (w_pop && r_count > (c_ptr_w + 1)'(1)) begin
                {key_release, key_code} <= r_mem[w_rd_next];
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Function : Directed bench for keypad_scan_fifo with a frame-level key model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;
    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_TICKS = 16;
    localparam int DEBOUNCE   = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int CODE_W     = 4;
    localparam int PERIOD     = SCAN_TICKS + COLS + 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [ROWS-1:0]   row_n;
    logic [COLS-1:0]   col_n;
    logic              key_valid;
    logic              key_ready;
    logic [CODE_W-1:0] key_code;
    logic              key_release;
    logic              key_held;
    logic              overflow;
    logic              overflow_clr;

    keypad_scan_fifo #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_TICKS(SCAN_TICKS),
        .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_ready(key_ready), .key_code(key_code),
        .key_release(key_release), .key_held(key_held), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Key matrix: keys changes only at frame boundaries, taken from next_keys.
    logic [15:0] keys      = '0;
    logic [15:0] next_keys = '0;

    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++) begin
            if (!row_n[r]) begin
                for (int c = 0; c < COLS; c++) begin
                    if (keys[r*COLS + c]) col_n[c] = 1'b0;
                end
            end
        end
    end

    // Frame-level model: debounced key states, expected event queue, overflow.
    bit [15:0] m_st;
    int        m_cnt [16];
    bit        m_ovf;
    int        q[$];
    int        popped[$];
    int        popcyc[$];
    int        m_row, last_chg, cyc, frame_cnt;
    bit        need_proc, have_prev, prev_hold, held_seen;
    int        prev_ev, ev_now, r_now, k;
    bit        s;

    always @(negedge clk) begin
        cyc++;
        if (key_held) held_seen = 1'b1;
        if (rst) begin
            q.delete();
            m_st = '0;
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_ovf = 1'b0;
            m_row = 0;
            need_proc = 1'b1;
            have_prev = 1'b0;
            prev_hold = 1'b0;
        end else begin
            ev_now = int'({key_release, key_code});
            r_now = -1;
            for (int r = 0; r < ROWS; r++) if (!row_n[r]) r_now = r;
            chk("row_onehot", $countones(~row_n), 1);
            if (!need_proc && r_now != m_row) begin
                chk("row_order", r_now, (m_row + 1) % ROWS);
                if (have_prev) chk("row_period", cyc - last_chg, PERIOD);
                chk("held_at_row_end", int'(key_held), int'(|m_st));
                chk("ovf_at_row_end", int'(overflow), int'(m_ovf));
                chk("valid_at_row_end", int'(key_valid), int'(q.size() != 0));
                have_prev = 1'b1;
            end
            if (prev_hold) begin
                chk("hold_valid", int'(key_valid), 1);
                chk("hold_event", ev_now, prev_ev);
            end
            if (key_valid && key_ready) begin
                if (q.size() == 0) chk("spurious_pop", ev_now, -1);
                else chk("pop_event", ev_now, q.pop_front());
                popped.push_back(ev_now);
                popcyc.push_back(cyc);
            end
            prev_hold = key_valid && !key_ready;
            prev_ev   = ev_now;
            if (need_proc || r_now != m_row) begin
                last_chg = cyc;
                m_row    = r_now;
                if (r_now == 0) begin
                    keys = next_keys;
                    frame_cnt++;
                end
                need_proc = 1'b0;
                for (int c = 0; c < COLS; c++) begin
                    k = m_row * COLS + c;
                    s = keys[k];
                    if (s == m_st[k]) m_cnt[k] = 0;
                    else if (m_cnt[k] == DEBOUNCE - 1) begin
                        m_st[k] = s;
                        m_cnt[k] = 0;
                        if (q.size() < FIFO_DEPTH) q.push_back((int'(!s) << CODE_W) | k);
                        else m_ovf = 1'b1;
                    end else m_cnt[k]++;
                end
            end
        end
    end

    task automatic wait_frames(input int n);
        int target;
        int guard;
        target = frame_cnt + n;
        guard  = 0;
        while (frame_cnt < target && guard < n * ROWS * PERIOD + 200) begin
            @(posedge clk);
            guard++;
        end
        if (frame_cnt < target) chk("frame_timeout", frame_cnt, target);
        #2;
    endtask

    initial begin
        rst = 1'b1; key_ready = 1'b1; overflow_clr = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_row_n", int'(row_n), 4'b1110);
        chk("rst_valid", int'(key_valid), 0);
        chk("rst_held", int'(key_held), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_code", int'({key_release, key_code}), 0);
        rst = 1'b0;

        // Idle scan
        wait_frames(2);
        chk("idle_valid", int'(key_valid), 0);
        chk("idle_ovf", int'(overflow), 0);

        // Single key 9 press then release
        popped.delete(); popcyc.delete();
        next_keys = 16'h0200;
        wait_frames(5);
        chk("k9_held", int'(key_held), 1);
        next_keys = '0;
        wait_frames(5);
        chk("k9_released", int'(key_held), 0);
        chk("k9_count", popped.size(), 2);
        if (popped.size() == 2) begin
            chk("k9_press", popped[0], 9);
            chk("k9_release", popped[1], 16 + 9);
        end

        // Bouncing key 5
        popped.delete(); held_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            next_keys = (i % 2 == 0) ? 16'h0020 : 16'h0000;
            wait_frames(1);
        end
        next_keys = '0;
        wait_frames(2);
        chk("bounce_events", popped.size(), 0);
        chk("bounce_held", int'(held_seen), 0);

        // Keys 0,1,2 together
        popped.delete(); popcyc.delete();
        next_keys = 16'h0007;
        wait_frames(4);
        chk("k012_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("k012_ev0", popped[0], 0);
            chk("k012_ev1", popped[1], 1);
            chk("k012_ev2", popped[2], 2);
            chk("k012_gap1", popcyc[1] - popcyc[0], 1);
            chk("k012_gap2", popcyc[2] - popcyc[1], 1);
        end
        next_keys = '0;
        wait_frames(4);
        chk("k012_rel_count", popped.size(), 6);

        // Overflow: 9 presses into an 8-deep FIFO with no consumer
        key_ready = 1'b0;
        popped.delete();
        next_keys = 16'h01FF;
        wait_frames(4);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_valid", int'(key_valid), 1);
        chk("ovf_head", int'({key_release, key_code}), 0);
        chk("ovf_model_q", q.size(), 8);
        key_ready = 1'b1;
        repeat (25) @(posedge clk);
        #2;
        chk("ovf_pop_count", popped.size(), 8);
        if (popped.size() == 8) begin
            for (int i = 0; i < 8; i++) chk("ovf_pop_order", popped[i], i);
        end
        chk("ovf_sticky", int'(overflow), 1);
        overflow_clr = 1'b1;
        @(posedge clk);
        #2;
        overflow_clr = 1'b0;
        m_ovf = 1'b0;
        chk("ovf_cleared", int'(overflow), 0);
        popped.delete();
        next_keys = '0;
        wait_frames(4);
        chk("ovf_rel_count", popped.size(), 9);

        // Reset mid-dwell with queued events; held keys re-report
        key_ready = 1'b0;
        next_keys = 16'h0448;
        wait_frames(4);
        chk("pre_rst_valid", int'(key_valid), 1);
        chk("pre_rst_q", q.size(), 3);
        wait_frames(1);
        repeat (30) @(posedge clk);
        #1;
        chk("pre_rst_row", int'(row_n), 4'b1101);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(key_valid), 0);
        chk("rst_mid_row", int'(row_n), 4'b1110);
        chk("rst_mid_held", int'(key_held), 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        key_ready = 1'b1;
        popped.delete();
        wait_frames(5);
        chk("repress_count", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("repress_ev0", popped[0], 3);
            chk("repress_ev1", popped[1], 6);
            chk("repress_ev2", popped[2], 10);
        end
        chk("repress_held", int'(key_held), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
